axis_ctr_rx: RTL and testbench
==============================

Name: axis_ctr_rx

Overview:
AXI4-Stream slave that consumes the incrementing counter stream emitted by our counter transmitter and checks it. It tracks the expected next value, counts accepted beats and sequence errors, and flags master-side handshake violations. Programmable backpressure on tready exercises the transmitter's stall behaviour. It sits at the sink end of loopback and bring-up paths as a self-checking consumer.

Parameters:
byte_width, 4, tdata width in bytes; tdata is 8*byte_width bits.
STALL_PATTERN, 8'h00, per-cycle stall mask; bit i set drops tready in slot i of a repeating 8-cycle window.
ERR_CNT_WIDTH, 16, width of the saturating error counter.
SYNC_ON_FIRST, 1, 1: first accepted beat seeds the expected value; 0: expected value starts at 0 and the first beat is checked.

Ports:
clk  input  1  clock; all logic on rising edge.
resetn  input  1  reset, synchronous, active-low.
tvalid  input  1  stream valid from master.
tready  output  1  stream ready to master.
tdata  input  8*byte_width  stream data (counter value).
tlast  input  1  end of packet; every beat must have tlast=1.
expected  output  8*byte_width  next expected tdata value.
beat_count  output  32  accepted beats since reset; wraps modulo 2^32.
err_count  output  ERR_CNT_WIDTH  sequence and tlast errors; saturates at all-ones.
err_sticky  output  1  set on the first error; cleared only by reset.
proto_err  output  1  sticky master handshake violation flag.
locked  output  1  high once the checker is synchronised (state LOCKED).

Behaviour:
- Handshake: a beat is accepted on a rising clk with tvalid && tready && resetn.
- Reset (resetn=0 at a clock edge):
  - tready=0, expected=0, beat_count=0, err_count=0, err_sticky=0, proto_err=0, locked=0.
  - State HUNT; stall slot pointer ptr (3 bits) = 0.
- tready is registered and independent of tvalid.
  - Each cycle out of reset: ptr <= ptr+1 (wraps at 8), tready <= ~STALL_PATTERN[ptr].
  - So tready is first valid on the second edge after reset release: the first cycle shows ~STALL_PATTERN[0], the next ~STALL_PATTERN[1], and so on, period 8.
  - STALL_PATTERN=8'h00 gives tready=1 continuously from the first cycle after reset.
- States:
  - HUNT, locked=0:
    - SYNC_ON_FIRST=1: the first accepted beat sets expected <= tdata+1, increments beat_count, moves to LOCKED, and raises no error. A tlast=0 on this beat is still an error.
    - SYNC_ON_FIRST=0: the state machine leaves HUNT on the first clock after reset, goes to LOCKED, and checks every beat including the first against expected=0.
  - LOCKED, locked=1, for each accepted beat:
    - beat_count++.
    - If tdata != expected or tlast=0: err_count++ (saturating) and err_sticky <= 1.
    - A sequence error and tlast=0 on the same beat count as one error, not two.
    - expected <= tdata+1 always, so the checker resynchronises to the received value and flags one error per discontinuity, not a cascade.
- Arithmetic: expected is computed modulo 2^(8*byte_width). tdata=all-ones followed by 0 is correct and raises no error.
- Protocol check (LOCKED and HUNT):
  - When tvalid=1 and tready=0 at an edge, the values of tvalid and tdata are captured.
  - If on the next edge tvalid=0, or tdata differs from the captured value, proto_err <= 1 (sticky).
  - proto_err does not affect err_count.
- Reset mid-stream: all state is cleared at that edge and any beat presented in that cycle is not accepted. With SYNC_ON_FIRST=1, the next accepted beat re-seeds the checker.
- All outputs are registered; error and count updates are visible the cycle after the accepting edge.

Test Plan:
- STALL_PATTERN=0, SYNC_ON_FIRST=1; master sends 0..9 with tlast=1, tvalid held high -> beat_count=10, expected=10, err_count=0, locked=1 after the first beat, proto_err=0.
- Wrap, byte_width=4: send 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0 -> expected=1, err_count=0.
- Gap and resync: send 5,6,8,9 -> err_count=1 (raised one cycle after beat 8), err_sticky=1, final expected=10; beat 9 raises no further error.
- tlast=0 on beat 3 of 0..5 -> err_count=1. SYNC_ON_FIRST=0 with first beat 7 -> err_count=1 and expected=8.
- STALL_PATTERN=8'b0000_0101, master holds tvalid=1 with data 0..15 -> tready low in window slots 0 and 2 (first and third cycle of every 8 after reset), 16 beats accepted, err_count=0. Master dropping tvalid during a stall, or changing tdata during a stall -> proto_err=1.
- Reset mid-stream after 4 beats -> all outputs 0 and locked=0 the following cycle. Then send 100,101 -> no error, expected=102. ERR_CNT_WIDTH=2 with 5 discontinuities -> err_count=3 (saturated).

Source files
------------

// File: rtl/axis_ctr_rx.sv
// axis_ctr_rx: AXI4-Stream sink that checks an incrementing counter stream and flags handshake violations
module axis_ctr_rx #(
    parameter int         byte_width    = 4,
    parameter logic [7:0] STALL_PATTERN = 8'h00,
    parameter int         ERR_CNT_WIDTH = 16,
    parameter bit         SYNC_ON_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     tvalid_i,
    output logic                     tready_o,
    input  logic [8*byte_width-1:0]  tdata_i,
    input  logic                     tlast_i,
    output logic [8*byte_width-1:0]  expected_o,
    output logic [31:0]              beat_count_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic                     err_sticky_o,
    output logic                     proto_err_o,
    output logic                     locked_o
);
    localparam int DW = 8*byte_width;
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [2:0]               ptr_q;
    logic                     tready_q;
    logic [DW-1:0]            exp_q, exp_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic                     sticky_q, sticky_d;
    logic                     proto_q, proto_d;
    logic                     pend_q;
    logic [DW-1:0]            cap_q;
    logic                     accept;
    logic                     checking;
    logic                     beat_err;

    assign accept   = tvalid_i && tready_q;
    // Without seeding, the very first beat is already held against expected=0.
    assign checking = (state_q == LOCKED) || !SYNC_ON_FIRST;
    // A sequence error and a missing tlast on one beat collapse into a single error.
    assign beat_err = accept && (!tlast_i || (checking && tdata_i != exp_q));

    // Next-state for lock state, expected value, counters and the sticky protocol flag
    always_comb begin
        state_d  = (!SYNC_ON_FIRST || accept) ? LOCKED : state_q;
        exp_d    = accept ? tdata_i + DW'(1) : exp_q;
        cnt_d    = cnt_q + 32'(accept);
        err_d    = (beat_err && err_q != '1) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
        sticky_d = sticky_q || beat_err;
        proto_d  = proto_q || (pend_q && (!tvalid_i || tdata_i != cap_q));
    end

    // Registered state, backpressure pattern and stalled-beat capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= HUNT;
            ptr_q    <= 3'd0;
            tready_q <= 1'b0;
            exp_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            sticky_q <= 1'b0;
            proto_q  <= 1'b0;
            pend_q   <= 1'b0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_q + 3'd1;
            tready_q <= !STALL_PATTERN[ptr_q];
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            proto_q  <= proto_d;
            pend_q   <= tvalid_i && !tready_q;
            cap_q    <= tdata_i;
        end
    end

    assign tready_o     = tready_q;
    assign expected_o   = exp_q;
    assign beat_count_o = cnt_q;
    assign err_count_o  = err_q;
    assign err_sticky_o = sticky_q;
    assign proto_err_o  = proto_q;
    assign locked_o     = (state_q == LOCKED);
endmodule

// File: tb/tb_axis_ctr_rx.sv
// tb_axis_ctr_rx: scoreboard bench for the counter-stream checker across several parameter sets
module tb_axis_ctr_rx;
    typedef struct packed {
        logic [31:0] exp;
        logic [31:0] cnt;
        logic [15:0] err;
        logic        stk;
    } sb_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b1;
    logic [31:0] tdata = '0;
    logic        tvalid2 = 1'b0;
    logic [31:0] tdata2 = '0;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic [31:0] exp0, exp1, exp2, exp3;
    logic [31:0] cnt0, cnt1, cnt2, cnt3;
    logic [15:0] err0, err1, err2;
    logic [1:0]  err3;
    logic        stk0, stk1, stk2, stk3;
    logic        pe0, pe1, pe2, pe3;
    logic        lk0, lk1, lk2, lk3;

    int          checks = 0;
    int          failures = 0;
    sb_t         q[$];
    sb_t         e;
    logic [31:0] m_exp, m_cnt;
    logic [15:0] m_err;
    logic        m_stk, m_lk;
    logic        acc = 1'b0;
    logic [7:0]  sp = 8'b0000_0101;

    always #5 clk = ~clk;

    axis_ctr_rx u0 (
        .clk(clk), .resetn(resetn), .tvalid_i(tvalid), .tready_o(rdy0), .tdata_i(tdata), .tlast_i(tlast),
        .expected_o(exp0), .beat_count_o(cnt0), .err_count_o(err0), .err_sticky_o(stk0),
        .proto_err_o(pe0), .locked_o(lk0)
    );

    axis_ctr_rx #(.SYNC_ON_FIRST(1'b0)) u1 (
        .clk(clk), .resetn(resetn), .tvalid_i(tvalid), .tready_o(rdy1), .tdata_i(tdata), .tlast_i(tlast),
        .expected_o(exp1), .beat_count_o(cnt1), .err_count_o(err1), .err_sticky_o(stk1),
        .proto_err_o(pe1), .locked_o(lk1)
    );

    axis_ctr_rx #(.STALL_PATTERN(8'b0000_0101)) u2 (
        .clk(clk), .resetn(resetn), .tvalid_i(tvalid2), .tready_o(rdy2), .tdata_i(tdata2), .tlast_i(1'b1),
        .expected_o(exp2), .beat_count_o(cnt2), .err_count_o(err2), .err_sticky_o(stk2),
        .proto_err_o(pe2), .locked_o(lk2)
    );

    axis_ctr_rx #(.ERR_CNT_WIDTH(2)) u3 (
        .clk(clk), .resetn(resetn), .tvalid_i(tvalid), .tready_o(rdy3), .tdata_i(tdata), .tlast_i(tlast),
        .expected_o(exp3), .beat_count_o(cnt3), .err_count_o(err3), .err_sticky_o(stk3),
        .proto_err_o(pe3), .locked_o(lk3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    // Drive one beat on the shared bus and push what u0 should show after accepting it
    task automatic send(input logic [31:0] d, input logic l);
        logic bad;
        @(negedge clk);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        bad = !l || (m_lk && d != m_exp);
        if (bad) begin
            m_stk = 1'b1;
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end
        m_exp = d + 32'd1;
        m_cnt = m_cnt + 32'd1;
        m_lk  = 1'b1;
        q.push_back(sb_t'{m_exp, m_cnt, m_err, m_stk});
    endtask

    task automatic idle();
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    // Assert reset for one edge (leaving tvalid as it was), check the cleared state, release
    task automatic rst_seq();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_tready", rdy0, 0);
        chk("rst_expected", exp0, 0);
        chk("rst_beats", cnt0, 0);
        chk("rst_errs", err0, 0);
        chk("rst_sticky", stk0, 0);
        chk("rst_proto", pe0, 0);
        chk("rst_locked", lk0, 0);
        chk("rst_locked_s0", lk1, 0);
        chk("sb_drain", 64'(q.size()), 0);
        q.delete();
        m_exp = '0; m_cnt = '0; m_err = '0; m_stk = 1'b0; m_lk = 1'b0;
        tvalid = 1'b0; tlast = 1'b1; tvalid2 = 1'b0; tdata2 = '0;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Record u0 acceptances at the edge, compare one cycle later against the scoreboard
    always @(posedge clk) acc <= resetn && tvalid && rdy0;

    always @(negedge clk) begin
        if (acc) begin
            if (q.size() == 0) begin
                chk("sb_empty", 64'(q.size()), 1);
            end else begin
                e = q.pop_front();
                chk("sb_expected", exp0, e.exp);
                chk("sb_beats", cnt0, e.cnt);
                chk("sb_errs", err0, e.err);
                chk("sb_sticky", stk0, e.stk);
                chk("sb_locked", lk0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic r;
        rst_seq();
        for (int i = 0; i < 10; i++) send(32'(i), 1'b1);
        idle();
        chk("basic_expected", exp0, 10);
        chk("basic_beats", cnt0, 10);
        chk("basic_proto", pe0, 0);

        rst_seq();
        send(32'hFFFF_FFFE, 1'b1);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h0, 1'b1);
        idle();
        chk("wrap_expected", exp0, 1);
        chk("wrap_errs", err0, 0);

        rst_seq();
        send(32'd5, 1'b1);
        send(32'd6, 1'b1);
        send(32'd8, 1'b1);
        send(32'd9, 1'b1);
        idle();
        chk("gap_errs", err0, 1);
        chk("gap_sticky", stk0, 1);
        chk("gap_expected", exp0, 10);

        rst_seq();
        for (int i = 0; i < 6; i++) send(32'(i), i != 3);
        idle();
        chk("tlast_errs", err0, 1);

        rst_seq();
        chk("s0_locked_early", lk1, 1);
        send(32'd7, 1'b1);
        idle();
        chk("s0_errs", err1, 1);
        chk("s0_expected", exp1, 8);
        chk("s1_seed_errs", err0, 0);

        rst_seq();
        for (int i = 0; i < 6; i++) send(32'(2 * i), 1'b1);
        idle();
        chk("sat_errs_w2", err3, 3);
        chk("sat_errs_w16", err0, 5);

        rst_seq();
        for (int i = 0; i < 4; i++) send(32'(i), 1'b1);
        rst_seq();
        send(32'd100, 1'b1);
        send(32'd101, 1'b1);
        idle();
        chk("reseed_expected", exp0, 102);
        chk("reseed_errs", err0, 0);

        rst_seq();
        n = 0;
        r = rdy2;
        chk("stall_slot0", rdy2, !sp[0]);
        tvalid2 = 1'b1;
        tdata2  = 32'd0;
        for (int c = 1; c < 64 && n < 16; c++) begin
            @(negedge clk);
            if (r) begin
                n++;
                if (n == 16) tvalid2 = 1'b0;
                else tdata2 = 32'(n);
            end
            r = rdy2;
            chk("stall_slot", rdy2, !sp[c % 8]);
        end
        chk("stall_accepted", 64'(n), 16);
        chk("stall_beats", cnt2, 16);
        chk("stall_expected", exp2, 16);
        chk("stall_errs", err2, 0);
        chk("stall_proto", pe2, 0);

        rst_seq();
        chk("drop_stalled", rdy2, 0);
        tvalid2 = 1'b1;
        tdata2  = 32'd5;
        @(negedge clk);
        tvalid2 = 1'b0;
        @(negedge clk);
        chk("drop_proto", pe2, 1);
        chk("drop_errs", err2, 0);

        rst_seq();
        tvalid2 = 1'b1;
        tdata2  = 32'd5;
        @(negedge clk);
        tdata2 = 32'd6;
        @(negedge clk);
        tvalid2 = 1'b0;
        @(negedge clk);
        chk("change_proto", pe2, 1);
        chk("clean_proto", pe0, 0);
        chk("sb_final", 64'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
